eaglesong_sponge_ctrl: RTL and testbench



---
 rtl/eaglesong_sponge_ctrl.sv | 176 +++++++++++++++++
 tb/tb_eaglesong_sponge_ctrl.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eaglesong_sponge_ctrl.sv
// Sponge-mode initiator for the iterative Eaglesong permutation engine: absorbs a byte stream,
// pads, sequences one permutation per 256-bit block and presents the digest. Optional counters: EAGLESONG_SPONGE_PERF_CNT_EN.
module eaglesong_sponge_ctrl #(
  parameter logic [7:0] DELIM = 8'h06
`ifdef EAGLESONG_SPONGE_PERF_CNT_EN
  , parameter int PERF_CNT_W = 16
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  // valid/ready on both streams: a transfer happens on a rising edge where valid and ready are
  // both high; the producer holds its data stable until then.
  input  logic [31:0]       msg_word,
  input  logic              msg_valid,
  input  logic              msg_last,
  input  logic [2:0]        msg_nbytes,
  output logic              msg_ready,
  output logic [15:0][31:0] perm_state,
  output logic              perm_start,
  input  logic [15:0][31:0] perm_result,
  input  logic              perm_done,
  output logic [255:0]      digest,
  output logic              digest_valid,
  input  logic              digest_ready,
  output logic [2:0]        o_dbg_state
`ifdef EAGLESONG_SPONGE_PERF_CNT_EN
  , output logic [PERF_CNT_W-1:0] perm_count
  , output logic [PERF_CNT_W-1:0] busy_cycles
`endif
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ABSORB = 3'd1;
  localparam logic [2:0] S_PAD    = 3'd2;
  localparam logic [2:0] S_PSTART = 3'd3;
  localparam logic [2:0] S_PWAIT  = 3'd4;
  localparam logic [2:0] S_OUT    = 3'd5;

  logic [2:0]        r_state;
  logic [2:0]        r_widx;
  logic              r_final;
  logic              r_delim_pending;
  logic [15:0][31:0] r_st;
  logic [255:0]      r_digest;

  logic [2:0]        w_nb;
  logic [31:0]       w_last_word;
  logic [31:0]       w_absorb_word;
  logic              w_hs;
  logic [255:0]      w_digest;
  logic [3:0]        w_widx;

  assign w_nb          = (msg_nbytes > 3'd4) ? 3'd4 : msg_nbytes;
  assign w_absorb_word = msg_last ? w_last_word : msg_word;
  assign w_hs          = msg_valid && (r_state == S_ABSORB);
  assign w_widx        = {1'b0, r_widx};

  // Last word: keep bytes below nbytes, place the delimiter right after them, zero the rest.
  always_comb begin
    w_last_word = '0;
    for (int k = 0; k < 4; k++) begin
      if (3'(k) < w_nb) w_last_word[31-8*k -: 8] = msg_word[31-8*k -: 8];
      else if (3'(k) == w_nb) w_last_word[31-8*k -: 8] = DELIM;
    end
  end

  // Digest bytes are read little-endian out of each of the eight rate words.
  always_comb begin
    w_digest = '0;
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 4; k++) begin
        w_digest[255-8*(4*j+k) -: 8] = perm_result[j][8*k+7 -: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_widx          <= 3'd0;
      r_final         <= 1'b0;
      r_delim_pending <= 1'b0;
      r_st            <= '0;
      r_digest        <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_st            <= '0;
          r_widx          <= 3'd0;
          r_final         <= 1'b0;
          r_delim_pending <= 1'b0;
          r_state         <= S_ABSORB;
        end
        S_ABSORB: begin
          if (w_hs) begin
            r_st[w_widx] <= r_st[w_widx] ^ w_absorb_word;
            if (!msg_last) begin
              if (r_widx != 3'd7) begin
                r_widx <= r_widx + 3'd1;
              end else begin
                r_final <= 1'b0;
                r_state <= S_PSTART;
              end
            end else if (w_nb != 3'd4) begin
              r_final <= 1'b1;
              r_state <= S_PSTART;
            end else begin
              // Full last word: the delimiter goes into the next word, possibly of the next block.
              r_delim_pending <= 1'b1;
              if (r_widx != 3'd7) begin
                r_widx  <= r_widx + 3'd1;
                r_state <= S_PAD;
              end else begin
                r_final <= 1'b0;
                r_widx  <= 3'd0;
                r_state <= S_PSTART;
              end
            end
          end
        end
        S_PAD: begin
          r_st[w_widx]    <= r_st[w_widx] ^ {DELIM, 24'h0};
          r_delim_pending <= 1'b0;
          r_final         <= 1'b1;
          r_state         <= S_PSTART;
        end
        S_PSTART: r_state <= S_PWAIT;
        S_PWAIT: begin
          if (perm_done) begin
            r_st   <= perm_result;
            r_widx <= 3'd0;
            if (r_delim_pending) begin
              r_state <= S_PAD;
            end else if (r_final) begin
              r_digest <= w_digest;
              r_state  <= S_OUT;
            end else begin
              r_state <= S_ABSORB;
            end
          end
        end
        S_OUT: if (digest_ready) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign msg_ready    = (r_state == S_ABSORB);
  assign perm_start   = (r_state == S_PSTART);
  assign digest_valid = (r_state == S_OUT);
  assign perm_state   = r_st;
  assign digest       = r_digest;
  assign o_dbg_state  = r_state;

`ifdef EAGLESONG_SPONGE_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] r_perm_count;
  logic [PERF_CNT_W-1:0] r_busy_cycles;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perm_count  <= '0;
      r_busy_cycles <= '0;
    end else if (r_state == S_IDLE) begin
      r_perm_count  <= '0;
      r_busy_cycles <= '0;
    end else begin
      if ((r_state == S_PSTART) && (r_perm_count != '1)) r_perm_count <= r_perm_count + 1'b1;
      if ((r_state != S_OUT) && (r_busy_cycles != '1)) r_busy_cycles <= r_busy_cycles + 1'b1;
    end
  end

  assign perm_count  = r_perm_count;
  assign busy_cycles = r_busy_cycles;
`endif

endmodule

// File: tb/tb_eaglesong_sponge_ctrl.sv
// Bench for eaglesong_sponge_ctrl: a stand-in permutation engine, a byte-stream sponge model,
// table-driven and random messages, backpressure and mid-run reset sequences.
module tb_eaglesong_sponge_ctrl;
  localparam logic [7:0] DELIM = 8'h06;
  typedef logic [15:0][31:0] st_t;
  typedef logic [7:0] bq_t[$];
  typedef struct {
    int          len;
    bit          bad_nb;
    logic [31:0] exp_w0;
    int          exp_blocks;
  } vec_t;

  logic         clk, rst_n;
  logic [31:0]  msg_word;
  logic         msg_valid, msg_last, msg_ready;
  logic [2:0]   msg_nbytes;
  st_t          perm_state, perm_result;
  logic         perm_start, perm_done;
  logic [255:0] digest;
  logic         digest_valid, digest_ready;
  logic [2:0]   dbg_state;
`ifdef EAGLESONG_SPONGE_PERF_CNT_EN
  logic [15:0]  perm_count, busy_cycles;
`endif

  eaglesong_sponge_ctrl #(.DELIM(DELIM)) dut (
    .clk(clk), .rst_n(rst_n),
    .msg_word(msg_word), .msg_valid(msg_valid), .msg_last(msg_last),
    .msg_nbytes(msg_nbytes), .msg_ready(msg_ready),
    .perm_state(perm_state), .perm_start(perm_start),
    .perm_result(perm_result), .perm_done(perm_done),
    .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .o_dbg_state(dbg_state)
`ifdef EAGLESONG_SPONGE_PERF_CNT_EN
    , .perm_count(perm_count), .busy_cycles(busy_cycles)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  logic [255:0] exp_q[$];
  st_t          exp_st_q[$];
  st_t          start_log[$];
  int           eng_cnt = 0;
  int           lat_min = 1;
  int           lat_max = 6;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Stand-in permutation: any fixed mixing function serves to exercise the controller.
  function automatic st_t toy_perm(input st_t s);
    st_t r;
    for (int i = 0; i < 16; i++)
      r[i] = {s[i][26:0], s[i][31:27]} ^ s[(i+1)%16] ^ (32'h9e3779b9 * 32'(i+1));
    return r;
  endfunction

  // Engine model: restarts on perm_start, raises done after a random latency and keeps it high.
  always @(negedge clk) begin
    if (perm_start === 1'b1) begin
      start_log.push_back(perm_state);
      perm_done   = 1'b0;
      perm_result = toy_perm(perm_state);
      eng_cnt     = $urandom_range(lat_max, lat_min);
    end else if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) perm_done = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  function automatic int model_run(input bq_t m);
    bq_t p;
    st_t s;
    logic [255:0] d;
    int nblk;
    p = m;
    p.push_back(DELIM);
    while (p.size() % 32 != 0) p.push_back(8'h00);
    nblk = p.size() / 32;
    s = '0;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 32; i++) s[i/4][31-8*(i%4) -: 8] ^= p[b*32+i];
      exp_st_q.push_back(s);
      s = toy_perm(s);
    end
    for (int n = 0; n < 32; n++) d[255-8*n -: 8] = s[n/4][8*(n%4)+7 -: 8];
    exp_q.push_back(d);
    return nblk;
  endfunction

  function automatic bq_t make_msg(input int len, input bit rnd);
    bq_t m;
    for (int i = 0; i < len; i++) m.push_back(rnd ? 8'($urandom) : 8'(8'h61 + i));
    return m;
  endfunction

  // ---------------- drivers ----------------
  task automatic send_msg(input bq_t m, input bit bad_nb, input bit gaps);
    int len, nw, nb, tmo;
    logic [31:0] wd;
    len = m.size();
    nw  = (len == 0) ? 1 : (len + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      repeat (gaps ? $urandom_range(0, 2) : 0) begin
        msg_valid = 1'b0;
        @(negedge clk);
      end
      for (int k = 0; k < 4; k++)
        wd[31-8*k -: 8] = (4*w + k < len) ? m[4*w+k] : 8'($urandom);
      nb = len - 4*w;
      if (nb > 4) nb = 4;
      msg_word  = wd;
      msg_last  = (w == nw - 1);
      msg_nbytes = (w == nw - 1) ? ((bad_nb && nb == 4) ? 3'd7 : 3'(nb)) : 3'($urandom_range(0, 7));
      msg_valid = 1'b1;
      tmo = 0;
      while (msg_ready !== 1'b1 && tmo <= 200) begin
        @(negedge clk);
        tmo++;
      end
      if (tmo > 200) begin
        check("msg_ready timeout", 0, 1);
        msg_valid = 1'b0;
        return;
      end
      @(posedge clk);
    end
    @(negedge clk);
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic recv_digest(input int hold, input int nblk, output logic [255:0] got);
    int tmo;
    logic [255:0] d0;
    tmo = 0;
    @(negedge clk);
    while (digest_valid !== 1'b1 && tmo <= 3000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo > 3000) check("digest_valid timeout", 0, 1);
    d0 = digest;
`ifdef EAGLESONG_SPONGE_PERF_CNT_EN
    check("perm_count", perm_count, nblk);
`else
    if (nblk < 0) check("nblk", nblk, 0);
`endif
    for (int c = 0; c < hold; c++) begin
      @(negedge clk);
      check("hold digest_valid", digest_valid, 1);
      check("hold digest stable", digest, d0);
      check("hold msg_ready", msg_ready, 0);
    end
    got = digest;
    digest_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    digest_ready = 1'b0;
    check("digest_valid drop", digest_valid, 0);
  endtask

  task automatic run_msg(input bq_t m, input bit bad_nb, input bit gaps, input int hold,
                         input string name, output logic [255:0] got);
    int nblk;
    start_log.delete();
    exp_st_q.delete();
    nblk = model_run(m);
    send_msg(m, bad_nb, gaps);
    recv_digest(hold, nblk, got);
    check({name, " blocks"}, start_log.size(), nblk);
    for (int b = 0; b < nblk && b < start_log.size(); b++)
      check($sformatf("%s blk%0d state", name, b), start_log[b], exp_st_q[b]);
    check({name, " digest"}, got, exp_q.pop_front());
  endtask

  // ---------------- test ----------------
  vec_t tbl[9];
  logic [255:0] d, abc_d;
  bq_t m;
  int tmo;

  initial begin
    tbl[0] = '{0,  1'b0, 32'h06000000, 1};
    tbl[1] = '{1,  1'b0, 32'h61060000, 1};
    tbl[2] = '{2,  1'b0, 32'h61620600, 1};
    tbl[3] = '{3,  1'b0, 32'h61626306, 1};
    tbl[4] = '{4,  1'b1, 32'h61626364, 1};
    tbl[5] = '{28, 1'b0, 32'h61626364, 1};
    tbl[6] = '{31, 1'b0, 32'h61626364, 1};
    tbl[7] = '{32, 1'b0, 32'h61626364, 2};
    tbl[8] = '{64, 1'b1, 32'h61626364, 3};

    rst_n = 1'b0; msg_word = '0; msg_valid = 1'b0; msg_last = 1'b0; msg_nbytes = '0;
    digest_ready = 1'b0; perm_done = 1'b0; perm_result = '0;
    repeat (3) @(negedge clk);
    check("reset msg_ready", msg_ready, 0);
    check("reset perm_start", perm_start, 0);
    check("reset digest_valid", digest_valid, 0);
    check("reset digest", digest, 0);
    check("reset perm_state", perm_state, 0);
    rst_n = 1'b1;

    for (int t = 0; t < 9; t++) begin
      m = make_msg(tbl[t].len, 1'b0);
      run_msg(m, tbl[t].bad_nb, 1'b1, t % 3, $sformatf("tbl%0d", t), d);
      check($sformatf("tbl%0d w0", t), start_log.size() > 0 ? start_log[0][0] : 32'hx, tbl[t].exp_w0);
      check($sformatf("tbl%0d nblk", t), start_log.size(), tbl[t].exp_blocks);
      if (tbl[t].len == 3) abc_d = d;
    end

    // 28 bytes: delimiter lands alone in rate word 7.
    m = make_msg(28, 1'b0);
    run_msg(m, 1'b0, 1'b0, 0, "len28", d);
    check("len28 word7", start_log.size() > 0 ? start_log[0][7] : 32'hx, 32'h06000000);

    // 32 bytes: second block starts from the first result with the delimiter in word 0.
    m = make_msg(32, 1'b0);
    run_msg(m, 1'b0, 1'b0, 0, "len32", d);
    check("len32 blk1 w0", start_log.size() > 1 ? start_log[1][0] : 32'hx,
          toy_perm(start_log[0])[0] ^ 32'h06000000);

    // Digest backpressure for 20 cycles.
    m = make_msg(40, 1'b1);
    run_msg(m, 1'b0, 1'b1, 20, "bp", d);

    // Randomized messages.
    for (int r = 0; r < 12; r++) begin
      m = make_msg($urandom_range(0, 70), 1'b1);
      run_msg(m, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 3), $sformatf("rnd%0d", r), d);
    end

    // Reset while waiting on the engine, then a clean "abc" run.
    lat_min = 8; lat_max = 10;
    m = make_msg(3, 1'b0);
    send_msg(m, 1'b0, 1'b0);
    tmo = 0;
    while (perm_start !== 1'b1 && tmo <= 50) begin
      @(negedge clk);
      tmo++;
    end
    check("rst perm_start seen", perm_start, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst msg_ready", msg_ready, 0);
    check("rst perm_start", perm_start, 0);
    check("rst digest_valid", digest_valid, 0);
    check("rst digest", digest, 0);
    check("rst perm_state", perm_state, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lat_min = 1; lat_max = 6;
    run_msg(m, 1'b0, 1'b0, 0, "abc after rst", d);
    check("abc digest repeat", d, abc_d);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    miscompares++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end

endmodule
